cond_issue_ctrl: RTL
====================

# cond_issue_ctrl

Conditional-issue controller between decode and execute of the CAL-ARM pipeline. It owns the architectural NZCV status register and evaluates each decoded instruction's 4-bit condition against it through the condition-evaluation sub-block. It stalls issue while a flag-setting instruction is still in flight and squashes the wrong-path slots after a taken branch. It emits a registered issue word to EX: valid, execute/suppress and branch-taken.

## Interface
- FLUSH_CYCLES, default 2: wrong-path slots discarded after a taken branch (1..7).
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  controller accepts it this cycle.
- id_cond  in  4  ARM condition field.
- id_s  in  1  instruction writes flags if executed.
- id_branch  in  1  instruction is a branch.
- flag_we  in  1  EX/multiplier writes flags this cycle.
- flag_in  in  4  new flags, [3]=N [2]=Z [1]=C [0]=V.
- ex_valid  out  1  issue slot valid (registered).
- ex_exec  out  1  condition passed; EX performs side effects (registered).
- ex_branch_taken  out  1  pulse: executed branch issued (registered).
- flags  out  4  current NZCV register, same bit order as flag_in.
- flush_active  out  1  controller in FLUSH.

## Operation
- Effective flags: eff = flag_we ? flag_in : flags_q. Effective pending: pend_eff = pending_q & ~flag_we. The flag write bypasses into the same-cycle evaluation.
- Condition codes 0000..1110 follow the ARM condition table: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL. Code 1111 is decided as "never", so exec=0.
- Stall rule: the instruction must wait when pend_eff=1 and either id_cond!=1110 or id_s=1. AL instructions without S issue past a pending flag write.
- Handshake: accept = id_valid & id_ready. In RUN, id_ready = ~stall. In STALL, id_ready=0. In FLUSH, id_ready=1.
- Issue: on accept in RUN or STALL, the next cycle carries ex_valid=1, ex_exec=cond_pass(eff,id_cond) and ex_branch_taken=ex_exec&id_branch.
- pending_q sets on accept with exec=1 & id_s=1. It clears on flag_we. Set has priority when both happen in the same cycle, because the write belongs to the older instruction.
- flags_q <= flag_in whenever flag_we=1, in any state. An unsolicited write, such as an MSR-style write, is legal.
- States:
  - RUN: normal issue. Goes to STALL when id_valid & stall. Goes to FLUSH on accept of an executed branch.
  - STALL: id_ready=0. Returns to RUN when stall clears (pend_eff=0). The instruction is then accepted in that same cycle from RUN logic, so the exit and the accept coincide.
  - FLUSH: a counter loads FLUSH_CYCLES. Each cycle with id_valid=1 consumes one slot; those instructions are accepted and discarded, and ex_valid=0. The controller returns to RUN when the count reaches 0. Cycles with id_valid=0 do not consume slots.
- Flag writes are never lost in FLUSH or STALL.

## Timing
- Reset values: flags=0000, pending_q=0, state=RUN, ex_valid=0, ex_exec=0, ex_branch_taken=0, flush_active=0, counter=0. id_ready=1 after reset.
- Latency: ex_* appear 1 cycle after accept. The flags output is the register, visible 1 cycle after flag_we.
- Stall release: a flag_we in cycle t allows the waiting instruction to be accepted in cycle t (bypass). Its ex_* appear at t+1.
- Taken branch accepted at t: ex_branch_taken=1 at t+1, and flush_active=1 from t+1 until FLUSH_CYCLES valid slots have been consumed.
- Reset asserted in any state returns the controller to RUN at the next edge and drops any in-progress flush or pending flag.
- id_valid may drop while the controller is in STALL. The controller then returns to RUN when pend_eff=0, or stays in RUN.

## Structure
- Package cond_pkg holds:
  - the cond_e enum (EQ..AL, NV=1111),
  - flag bit index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0,
  - the state_e enum {RUN, STALL, FLUSH}.
- Sub-module cond_eval: purely combinational (flags[3:0], cond[3:0]) -> pass. It defines all 16 codes, with 1111 -> 0 and no latch. The top instantiates it once on eff.

## Test plan
- Reset: after rst=1 then 0, flags=0000, ex_valid=0, id_ready=1. Issue EQ: ex_exec=0, because Z=0.
- Flag-setting op: issue ADDS with AL and S=1, then NE, then flag_we=1 with flag_in=0100 two cycles later. NE stalls (id_ready=0) until the flag_we cycle, issues that cycle, and ex_exec=0 next cycle.
- Bypass with AL: pending set, then an AL instruction without S issues with no stall. A following AL instruction with S stalls.
- Taken branch: flags=0000, issue B with cond=1110. ex_branch_taken=1 next cycle. With FLUSH_CYCLES=2, the next 2 valid instructions produce ex_valid=0, and the 3rd issues.
- NV code: cond=1111 gives ex_valid=1, ex_exec=0, and no pending set even with S=1.
- Reset mid-FLUSH and mid-STALL: the state returns to RUN, pending clears, and the next instruction issues immediately.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the conditional-issue controller: ARM condition codes, NZCV bit positions, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'ha, LT = 4'hb,
        GT = 4'hc, LE = 4'hd, AL = 4'he, NV = 4'hf
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

    // Registered issue word handed to EX.
    typedef struct packed {
        logic valid;
        logic exec;
        logic br_taken;
    } ex_word_t;

endpackage

// File: rtl/cond_eval.sv
// Evaluates a 4-bit ARM condition code against NZCV flags.
// Latency: combinational.
// Backpressure: none.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ:      pass = z;
            NE:      pass = ~z;
            CS:      pass = c;
            CC:      pass = ~c;
            MI:      pass = n;
            PL:      pass = ~n;
            VS:      pass = v;
            VC:      pass = ~v;
            HI:      pass = c & ~z;
            LS:      pass = ~c | z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = ~z & (n == v);
            LE:      pass = z | (n != v);
            AL:      pass = 1'b1;
            NV:      pass = 1'b0; // treated as "never" rather than the legacy unconditional space
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Decode->EX conditional-issue controller: owns NZCV, stalls on in-flight flag writes, squashes after taken branches.
// Latency: issue word registered, 1 cycle after accept; flag write bypasses into same-cycle evaluation.
// Backpressure: id_ready drops while a needed flag write is pending; wrong-path slots are accepted and discarded.
module cond_issue_ctrl
    import cond_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [3:0] id_cond,
    input  logic       id_s,
    input  logic       id_branch,
    input  logic       flag_we,
    input  logic [3:0] flag_in,
    output logic       ex_valid,
    output logic       ex_exec,
    output logic       ex_branch_taken,
    output logic [3:0] flags,
    output logic       flush_active
);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] flags_q;
    logic       pending_q;
    ex_word_t   ex_q;

    logic [3:0] eff_flags;
    logic       pend_eff;
    logic       stall;
    logic       pass;
    logic       issue;

    assign eff_flags = flag_we ? flag_in : flags_q;
    assign pend_eff  = pending_q & ~flag_we;
    // AL without S cannot observe or clobber the in-flight flags, so it may slip past.
    assign stall     = pend_eff & ((id_cond != AL) | id_s);

    cond_eval u_cond_eval (
        .flags (eff_flags),
        .cond  (id_cond),
        .pass  (pass)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        id_ready = 1'b1;
        issue    = 1'b0;
        case (state_q)
            RUN, STALL: begin
                // STALL exits and accepts in the same cycle the stall condition clears.
                id_ready = ~stall;
                issue    = id_valid & ~stall;
                if (issue & pass & id_branch) begin
                    state_d = FLUSH;
                    cnt_d   = 3'(FLUSH_CYCLES);
                end else if (id_valid & stall) begin
                    state_d = STALL;
                end else if ((state_q == STALL) & pend_eff) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                id_ready = 1'b1;
                if (id_valid) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 3'd0;
            flags_q   <= 4'b0000;
            pending_q <= 1'b0;
            ex_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flag_we) begin
                flags_q <= flag_in;
            end
            // The same-cycle write belongs to an older instruction, so a new setter wins.
            if (issue & pass & id_s) begin
                pending_q <= 1'b1;
            end else if (flag_we) begin
                pending_q <= 1'b0;
            end
            ex_q.valid    <= issue;
            ex_q.exec     <= issue & pass;
            ex_q.br_taken <= issue & pass & id_branch;
        end
    end

    assign ex_valid        = ex_q.valid;
    assign ex_exec         = ex_q.exec;
    assign ex_branch_taken = ex_q.br_taken;
    assign flags           = flags_q;
    assign flush_active    = (state_q == FLUSH);

endmodule
